n64_controller_responder: RTL and testbench

Device-side end of the N64 single-wire controller protocol: decodes command bytes driven by a console (or by `n64_serial_interface` in loopback benches) on the open-collector data line, and answers with status or button data using the controller's bit timing. Sits between the shared GPIO pad and a button-source block, so the board can emulate a controller or self-test the host-side polling logic.

---
 rtl/n64_controller_responder.sv | 169 ++++++++++++++++
 tb/tb_n64_controller_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/n64_controller_responder.sv
// N64 controller (device side): decodes console command bytes on the
// open-collector data line and answers status / button words with
// controller bit timing.
module n64_controller_responder #(
  parameter int CLK_PER_US    = 100,
  parameter int TURNAROUND_US = 2,
  parameter int TIMEOUT_US    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpio_in,
  output logic        gpio_out,
  input  logic [31:0] button_data,
  output logic [7:0]  cmd_byte,
  output logic        cmd_valid,
  output logic        reset_cmd,
  output logic        rx_error,
  output logic        busy
);

  localparam int BIT_CYC = 4 * CLK_PER_US;
  localparam int TO_CYC  = TIMEOUT_US * CLK_PER_US;
  localparam int TA_CYC  = TURNAROUND_US * CLK_PER_US;
  localparam int MAX_A   = (BIT_CYC > TO_CYC) ? BIT_CYC : TO_CYC;
  localparam int MAX_CYC = (MAX_A > TA_CYC) ? MAX_A : TA_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO_US    = CW'(2 * CLK_PER_US);
  localparam logic [CW-1:0] TO_C      = CW'(TO_CYC);
  localparam logic [CW-1:0] TA_C      = CW'(TA_CYC);
  localparam logic [CW-1:0] LOW1_END  = CW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] LOW0_END  = CW'(3 * CLK_PER_US - 1);
  localparam logic [CW-1:0] HIGH1_END = CW'(3 * CLK_PER_US - 1);
  localparam logic [CW-1:0] HIGH0_END = CW'(CLK_PER_US - 1);
  localparam logic [CW-1:0] STOP_END  = CW'(2 * CLK_PER_US - 1);

  typedef enum logic [3:0] {
    IDLE, RX_LOW, RX_HIGH, RX_STOP, TURNAROUND,
    TX_LOW, TX_HIGH, TX_STOP, WAIT_IDLE
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      sync;
  logic            d, d_prev, rise, fall;
  logic [CW-1:0]   cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      rx_shift;
  logic [31:0]     tx_shift;
  logic [5:0]      tx_left;
  logic            drive_low, cmd_strobe, err_strobe;

  assign d    = sync[2];
  assign rise = ~d_prev & d;
  assign fall = d_prev & ~d;

  // Three-flop synchronizer plus edge-detect history; idles high like the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= 3'b111;
      d_prev <= 1'b1;
    end else begin
      sync   <= {sync[1:0], gpio_in};
      d_prev <= d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (fall) state_nx = RX_LOW;
      RX_LOW:     if (rise) state_nx = RX_HIGH;
                  else if (err_strobe) state_nx = WAIT_IDLE;
      RX_HIGH:    if (fall) state_nx = (bit_cnt == 4'd8) ? RX_STOP : RX_LOW;
                  else if (err_strobe) state_nx = IDLE;
      RX_STOP:    if (rise) begin
                    unique case (rx_shift)
                      8'h00, 8'h01, 8'hFF: state_nx = TURNAROUND;
                      default:             state_nx = IDLE;
                    endcase
                  end else if (err_strobe) state_nx = WAIT_IDLE;
      TURNAROUND: if (err_strobe) state_nx = WAIT_IDLE;
                  else if (cnt == TA_C) state_nx = TX_LOW;
      TX_LOW:     if (cnt == (tx_shift[31] ? LOW1_END : LOW0_END)) state_nx = TX_HIGH;
      TX_HIGH:    if (cnt == (tx_shift[31] ? HIGH1_END : HIGH0_END))
                    state_nx = (tx_left == 6'd1) ? TX_STOP : TX_LOW;
      TX_STOP:    if (cnt == STOP_END) state_nx = WAIT_IDLE;
      WAIT_IDLE:  if (d && cnt >= TO_C) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Outputs and strobes decoded from state, line edges and the phase counter.
  always_comb begin
    drive_low  = (state == TX_LOW) || (state == TX_STOP);
    busy       = (state != IDLE);
    cmd_strobe = (state == RX_STOP) && rise;
    err_strobe = 1'b0;
    unique case (state)
      RX_LOW:     err_strobe = !rise && (cnt >= TO_C);
      RX_HIGH:    err_strobe = !fall && (cnt >= TO_C);
      RX_STOP:    err_strobe = !rise && (cnt >= TO_C);
      TURNAROUND: err_strobe = fall;
      default:    err_strobe = 1'b0;
    endcase
  end

  // Open collector: only ever pull low, otherwise release.
  assign gpio_out = drive_low ? 1'b0 : 1'bz;

  // Datapath: phase counter, receive/transmit shifters and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_left   <= '0;
      cmd_byte  <= '0;
      cmd_valid <= 1'b0;
      reset_cmd <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      cmd_valid <= cmd_strobe;
      reset_cmd <= cmd_strobe && (rx_shift == 8'hFF);
      rx_error  <= err_strobe;

      // Receive phases start at 1 because the edge cycle already belongs to
      // the new phase; WAIT_IDLE measures only continuous high time.
      if (state_nx != state)
        cnt <= (state_nx == RX_LOW || state_nx == RX_HIGH || state_nx == RX_STOP) ? ONE : '0;
      else if (state == WAIT_IDLE && !d)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;

      if (state == IDLE && fall) bit_cnt <= '0;
      if (state == RX_LOW && rise) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= {rx_shift[6:0], (cnt < TWO_US)};
      end

      // Snapshot the response word at decode so later button changes are ignored.
      if (cmd_strobe) begin
        cmd_byte <= rx_shift;
        if (rx_shift == 8'h01) begin
          tx_shift <= button_data;
          tx_left  <= 6'd32;
        end else begin
          tx_shift <= {24'h050002, 8'h00};
          tx_left  <= 6'd24;
        end
      end

      if (state == TX_HIGH && state_nx != TX_HIGH) begin
        tx_shift <= {tx_shift[30:0], 1'b0};
        tx_left  <= tx_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_n64_controller_responder.sv
// Directed bench: a console model drives commands on a pulled-up shared
// line and decodes the responder's answer from measured low/high widths.
module tb_n64_controller_responder;

  localparam int US = 20;   // CLK_PER_US used for this bench

  logic        clk = 1'b0;
  logic        reset;
  logic        con_low;
  logic [31:0] button_data;
  logic [7:0]  cmd_byte;
  logic        cmd_valid, reset_cmd, rx_error, busy;
  wire         line;

  pullup (line);
  assign line = con_low ? 1'b0 : 1'bz;

  n64_controller_responder #(.CLK_PER_US(US), .TURNAROUND_US(2), .TIMEOUT_US(5)) dut (
    .clk(clk), .reset(reset), .gpio_in(line), .gpio_out(line),
    .button_data(button_data), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
    .reset_cmd(reset_cmd), .rx_error(rx_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int n_valid = 0, n_rcmd = 0, n_err = 0;
  int lows[32], highs[32];
  int stop_len;
  logic [31:0] word;

  // Running pulse counts.
  always @(posedge clk) begin
    if (cmd_valid) n_valid <= n_valid + 1;
    if (reset_cmd) n_rcmd  <= n_rcmd + 1;
    if (rx_error)  n_err   <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All console tasks start and end on a falling clock edge.
  task automatic drive(input logic low, input int cyc);
    con_low = low;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, b[i] ? US : 3 * US);
      drive(1'b0, b[i] ? 3 * US : US);
    end
    drive(1'b1, US);
    con_low = 1'b0;
  endtask

  task automatic wait_cmd();
    int c = 0;
    while (cmd_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    chk("cmd_valid_seen", cmd_valid, 1'b1);
  endtask

  task automatic first_drive(input string tag);
    int c = 0;
    while (line !== 1'b0 && c < 200) begin @(negedge clk); c++; end
    chk(tag, c, 2 * US + 1);
  endtask

  // Starts on the first low sample of the response.
  task automatic rx_response(input int n, input int chg_bit, input logic [31:0] chg_val);
    int c;
    word = '0;
    for (int i = 0; i < n; i++) begin
      if (i == chg_bit) button_data = chg_val;
      c = 0;
      while (line === 1'b0 && c < 400) begin c++; @(negedge clk); end
      lows[i] = c;
      c = 0;
      while (line !== 1'b0 && c < 400) begin c++; @(negedge clk); end
      highs[i] = c;
      word = {word[30:0], (lows[i] < 2 * US)};
    end
    c = 0;
    while (line === 1'b0 && c < 400) begin c++; @(negedge clk); end
    stop_len = c;
  endtask

  task automatic wait_not_busy(input string tag);
    int c = 0;
    while (busy !== 1'b0 && c < 400) begin @(negedge clk); c++; end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int c, r0, e0, v0;
    reset = 1'b1; con_low = 1'b0; button_data = '0;
    repeat (5) @(negedge clk);
    chk("rst_cmd_byte", cmd_byte, 8'h00);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_reset_cmd", reset_cmd, 1'b0);
    chk("rst_rx_error", rx_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_line", line, 1'b1);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Poll 0x01 with buttons 0x800000FF.
    button_data = 32'h8000_00FF;
    send_byte(8'h01);
    wait_cmd();
    chk("poll_cmd_byte", cmd_byte, 8'h01);
    chk("poll_no_reset_cmd", reset_cmd, 1'b0);
    first_drive("poll_first_drive");
    rx_response(32, -1, '0);
    chk("poll_word", word, 32'h8000_00FF);
    chk("poll_low_b31", lows[0], US);
    chk("poll_high_b31", highs[0], 3 * US);
    chk("poll_low_b30", lows[1], 3 * US);
    chk("poll_low_b8", lows[23], 3 * US);
    chk("poll_low_b7", lows[24], US);
    chk("poll_low_b0", lows[31], US);
    chk("poll_period_b26", lows[5] + highs[5], 4 * US);
    chk("poll_stop_len", stop_len, 2 * US);
    wait_not_busy("poll_idle");

    // Reset command 0xFF answers status 0x050002.
    r0 = n_rcmd;
    send_byte(8'hFF);
    wait_cmd();
    chk("rstcmd_cmd_byte", cmd_byte, 8'hFF);
    chk("rstcmd_pulse_same_cycle", reset_cmd, 1'b1);
    first_drive("rstcmd_first_drive");
    rx_response(24, -1, '0);
    chk("rstcmd_word", word, 32'h0005_0002);
    chk("rstcmd_stop_len", stop_len, 2 * US);
    wait_not_busy("rstcmd_idle");
    chk("rstcmd_pulse_count", n_rcmd - r0, 1);

    // Unknown command: decoded, no response.
    send_byte(8'h42);
    wait_cmd();
    chk("unk_cmd_byte", cmd_byte, 8'h42);
    @(negedge clk);
    chk("unk_busy_low", busy, 1'b0);
    c = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (line === 1'b0) c++; end
    chk("unk_no_drive", c, 0);

    // 6 us low mid-command aborts; decoding waits for 5 us of idle line.
    e0 = n_err; v0 = n_valid;
    drive(1'b1, US); drive(1'b0, 3 * US);
    drive(1'b1, 3 * US); drive(1'b0, US);
    drive(1'b1, 6 * US);
    chk("to_err_pulse", n_err - e0, 1);
    chk("to_busy_wait", busy, 1'b1);
    drive(1'b0, 2 * US);
    send_byte(8'h00);
    c = 0;
    for (int i = 0; i < 160; i++) begin @(negedge clk); if (line === 1'b0) c++; end
    chk("to_no_decode", n_valid - v0, 0);
    chk("to_no_drive", c, 0);
    chk("to_back_idle", busy, 1'b0);

    // Button word is snapshotted at decode.
    button_data = 32'h0;
    send_byte(8'h01);
    wait_cmd();
    first_drive("snap_first_drive");
    rx_response(32, 10, 32'hFFFF_FFFF);
    chk("snap_word", word, 32'h0);
    wait_not_busy("snap_idle");

    // Reset in the middle of a 3 us low phase.
    button_data = 32'h0;
    send_byte(8'h01);
    wait_cmd();
    first_drive("mid_first_drive");
    repeat (30) @(negedge clk);
    chk("mid_driving", line, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_line", line, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", cmd_valid, 1'b0);
    chk("mid_rst_err", rx_error, 1'b0);
    chk("mid_rst_rcmd", reset_cmd, 1'b0);
    reset = 1'b0;
    c = 0;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (line === 1'b0) c++; end
    chk("mid_no_resume", c, 0);
    send_byte(8'hFF);
    wait_cmd();
    chk("mid_next_cmd_byte", cmd_byte, 8'hFF);
    first_drive("mid_next_first_drive");
    rx_response(24, -1, '0);
    chk("mid_next_word", word, 32'h0005_0002);
    wait_not_busy("mid_next_idle");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
